// File: rtl/memwb_skid_stage_if.sv
// MEM->WB handshake bundle for memwb_skid_stage: MEM-side entry, WB-side entry and both ready/valid pairs.
// The master modport belongs to the surrounding pipeline and the slave modport to the stage.
interface memwb_skid_stage_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg_write_addr;
    logic [DATA_W-1:0] in_mem_data;
    logic              in_reg_write_en;
    logic              in_mem_to_reg;
    logic [DATA_W-1:0] in_alu_out;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_reg_write_addr;
    logic              out_reg_write_en;
    logic              out_mem_to_reg;
    logic [DATA_W-1:0] out_wb_data;

    modport master (
        output in_valid, in_reg_write_addr, in_mem_data, in_reg_write_en,
               in_mem_to_reg, in_alu_out, out_ready,
        input  in_ready, out_valid, out_reg_write_addr, out_reg_write_en,
               out_mem_to_reg, out_wb_data
    );

    modport slave (
        input  in_valid, in_reg_write_addr, in_mem_data, in_reg_write_en,
               in_mem_to_reg, in_alu_out, out_ready,
        output in_ready, out_valid, out_reg_write_addr, out_reg_write_en,
               out_mem_to_reg, out_wb_data
    );
endinterface

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage with a two-entry (OUT + SKID) buffer, flush and a saturating stall counter.
// Define MEMWB_FWD_EN to add the registered forwarding port (fwd_valid/fwd_addr/fwd_data).
module memwb_skid_stage #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    memwb_skid_stage_if.slave bus,
`ifdef MEMWB_FWD_EN
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [15:0]       stall_cnt
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write_en;
        logic              mem_to_reg;
        logic [DATA_W-1:0] wb_data;
    } entry_t;

    entry_t      out_r, skid_r, out_n_s, skid_n_s, in_entry_s;
    logic        out_valid_r, skid_valid_r, out_valid_n_s, skid_valid_n_s;
    logic        in_ready_r, out_we_r, accept_s, stall_s;
    logic [15:0] stall_cnt_r;

    assign accept_s = bus.in_valid & ~skid_valid_r;
    assign stall_s  = bus.in_valid & skid_valid_r;

    // Capture the incoming entry with its write-back value already resolved
    always_comb begin
        in_entry_s.addr       = bus.in_reg_write_addr;
        in_entry_s.write_en   = bus.in_reg_write_en;
        in_entry_s.mem_to_reg = bus.in_mem_to_reg;
        if (bus.in_mem_to_reg) begin
            in_entry_s.wb_data = bus.in_mem_data;
        end else begin
            in_entry_s.wb_data = bus.in_alu_out;
        end
    end

    // Next-state of the OUT/SKID pair; SKID only ever refills OUT, never bypasses it
    always_comb begin
        out_n_s        = out_r;
        skid_n_s       = skid_r;
        out_valid_n_s  = out_valid_r;
        skid_valid_n_s = skid_valid_r;
        if (flush) begin
            out_n_s        = '0;
            skid_n_s       = '0;
            out_valid_n_s  = 1'b0;
            skid_valid_n_s = 1'b0;
        end else if (!out_valid_r || bus.out_ready) begin
            if (skid_valid_r) begin
                out_n_s        = skid_r;
                out_valid_n_s  = 1'b1;
                skid_valid_n_s = accept_s;
                if (accept_s) begin
                    skid_n_s = in_entry_s;
                end else begin
                    skid_n_s = skid_r;
                end
            end else begin
                out_valid_n_s = accept_s;
                if (accept_s) begin
                    out_n_s = in_entry_s;
                end else begin
                    out_n_s = out_r;
                end
            end
        end else begin
            if (accept_s) begin
                skid_n_s       = in_entry_s;
                skid_valid_n_s = 1'b1;
            end else begin
                skid_n_s       = skid_r;
                skid_valid_n_s = skid_valid_r;
            end
        end
    end

    // Entry registers plus the registered ready and gated write-enable outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r        <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_we_r     <= 1'b0;
        end else begin
            out_r        <= out_n_s;
            skid_r       <= skid_n_s;
            out_valid_r  <= out_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            in_ready_r   <= ~skid_valid_n_s;
            out_we_r     <= out_valid_n_s & out_n_s.write_en;
        end
    end

    // Saturating count of cycles where MEM offers an entry we cannot take
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (!flush && stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.in_ready           = in_ready_r;
    assign bus.out_valid          = out_valid_r;
    assign bus.out_reg_write_addr = out_r.addr;
    assign bus.out_reg_write_en   = out_we_r;
    assign bus.out_mem_to_reg     = out_r.mem_to_reg;
    assign bus.out_wb_data        = out_r.wb_data;
    assign stall_cnt              = stall_cnt_r;

`ifdef MEMWB_FWD_EN
    // OUT payload is cleared on flush and reset, so forwarding reads zero then
    assign fwd_valid = out_we_r;
    assign fwd_addr  = out_r.addr;
    assign fwd_data  = out_r.wb_data;
`endif
endmodule

// File: tb/tb_memwb_skid_stage.sv
// Self-checking bench for memwb_skid_stage: vector table for stream/back-pressure/flush,
// hand-written sequences for reset, mid-transfer reset, stall saturation and forwarding.
module tb_memwb_skid_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] stall_cnt;
    int          n_pass = 0;
    int          n_total = 0;
`ifdef MEMWB_FWD_EN
    logic       fwd_valid;
    logic [3:0] fwd_addr;
    logic [7:0] fwd_data;
`endif

    memwb_skid_stage_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    memwb_skid_stage #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
`ifdef MEMWB_FWD_EN
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
`endif
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] addr;
        logic [7:0] md;
        logic       we;
        logic       m2r;
        logic [7:0] alu;
        logic       ordy;
        logic       fl;
        logic       ov;
        logic       ir;
        logic       owe;
        logic       om2r;
        logic [3:0] oaddr;
        logic [7:0] odata;
        logic       cs;
        logic [15:0] st;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic iv, logic [3:0] addr, logic [7:0] md, logic we, logic m2r,
                                logic [7:0] alu, logic ordy, logic fl, logic ov, logic ir,
                                logic owe, logic om2r, logic [3:0] oaddr, logic [7:0] odata,
                                logic cs, logic [15:0] st);
        vec_t v;
        v.iv = iv; v.addr = addr; v.md = md; v.we = we; v.m2r = m2r; v.alu = alu;
        v.ordy = ordy; v.fl = fl; v.ov = ov; v.ir = ir; v.owe = owe; v.om2r = om2r;
        v.oaddr = oaddr; v.odata = odata; v.cs = cs; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] addr, input logic [7:0] md,
                         input logic we, input logic m2r, input logic [7:0] alu,
                         input logic ordy, input logic fl);
        bus.in_valid          = iv;
        bus.in_reg_write_addr = addr;
        bus.in_mem_data       = md;
        bus.in_reg_write_en   = we;
        bus.in_mem_to_reg     = m2r;
        bus.in_alu_out        = alu;
        bus.out_ready         = ordy;
        flush                 = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stream, back-pressure A/B/C, flush with full buffer, flush with out_ready
        vecs[0]  = mk(1'b1, 4'h3, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 8'h5A, 1'b1, 16'd0);
        vecs[1]  = mk(1'b1, 4'h3, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 8'hC3, 1'b1, 16'd0);
        vecs[2]  = mk(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 16'd0);
        vecs[3]  = mk(1'b1, 4'h1, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 8'h11, 1'b1, 16'd0);
        vecs[4]  = mk(1'b1, 4'h2, 8'h22, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 8'h11, 1'b1, 16'd0);
        vecs[5]  = mk(1'b1, 4'h4, 8'h00, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 8'h11, 1'b1, 16'd1);
        vecs[6]  = mk(1'b1, 4'h4, 8'h00, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 8'h11, 1'b1, 16'd2);
        vecs[7]  = mk(1'b1, 4'h4, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 8'h22, 1'b1, 16'd3);
        vecs[8]  = mk(1'b1, 4'h4, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 4'h4, 8'h44, 1'b1, 16'd3);
        vecs[9]  = mk(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 16'd3);
        vecs[10] = mk(1'b1, 4'h5, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 8'h55, 1'b1, 16'd3);
        vecs[11] = mk(1'b1, 4'h6, 8'h66, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 8'h55, 1'b1, 16'd3);
        vecs[12] = mk(1'b1, 4'h7, 8'h00, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 16'd0);
        vecs[13] = mk(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 16'd0);
        vecs[14] = mk(1'b1, 4'h8, 8'h00, 1'b0, 1'b0, 8'h88, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 8'h88, 1'b0, 16'd0);
        vecs[15] = mk(1'b1, 4'h9, 8'h00, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 16'd0);
        vecs[16] = mk(1'b1, 4'hA, 8'hBB, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 8'hBB, 1'b0, 16'd0);
        vecs[17] = mk(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 16'd0);

        // reset then idle
        rst = 1'b1;
        drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        chk("reset_outputs",
            {bus.out_valid, bus.in_ready, bus.out_reg_write_en, bus.out_mem_to_reg,
             bus.out_reg_write_addr, bus.out_wb_data, stall_cnt},
            {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 16'd0});
        rst = 1'b0;
        step();
        chk("idle_outputs",
            {bus.out_valid, bus.in_ready, bus.out_reg_write_en, bus.out_mem_to_reg,
             bus.out_reg_write_addr, bus.out_wb_data, stall_cnt},
            {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 16'd0});

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].iv, vecs[i].addr, vecs[i].md, vecs[i].we, vecs[i].m2r,
                  vecs[i].alu, vecs[i].ordy, vecs[i].fl);
            step();
            chk($sformatf("vec%0d_ctrl", i), {bus.out_valid, bus.in_ready, bus.out_reg_write_en},
                {vecs[i].ov, vecs[i].ir, vecs[i].owe});
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d_payload", i),
                    {bus.out_reg_write_addr, bus.out_mem_to_reg, bus.out_wb_data},
                    {vecs[i].oaddr, vecs[i].om2r, vecs[i].odata});
            end
            if (vecs[i].cs) begin
                chk($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].st);
            end
        end

        // reset with both entries full loses everything
        drive(1'b1, 4'h1, 8'h00, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'h2, 8'h00, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0);
        step();
        chk("midrst_full", {bus.out_valid, bus.in_ready}, {1'b1, 1'b0});
        rst = 1'b1;
        drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        chk("midrst_cleared",
            {bus.out_valid, bus.in_ready, bus.out_reg_write_en, bus.out_reg_write_addr,
             bus.out_wb_data, stall_cnt},
            {1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 16'd0});
        rst = 1'b0;
        step();
        chk("midrst_nothing_left", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});

        // stall counter saturation: two accepts fill OUT and SKID, then one count per cycle
        drive(1'b1, 4'h3, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        repeat (1002) step();
        chk("stall_1000", stall_cnt, 16'd1000);
        repeat (65537 - 1002) step();
        chk("stall_reach_max", stall_cnt, 16'hFFFF);
        repeat (100) step();
        chk("stall_saturated", stall_cnt, 16'hFFFF);
        chk("stall_hold_ctrl", {bus.out_valid, bus.in_ready}, {1'b1, 1'b0});

`ifdef MEMWB_FWD_EN
        rst = 1'b1;
        drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        chk("fwd_reset", {fwd_valid, fwd_addr, fwd_data}, {1'b0, 4'h0, 8'h00});
        rst = 1'b0;
        drive(1'b1, 4'h7, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
        step();
        chk("fwd_write", {fwd_valid, fwd_addr, fwd_data}, {1'b1, 4'h7, 8'h11});
        drive(1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0);
        step();
        chk("fwd_nowrite", fwd_valid, 1'b0);
        drive(1'b1, 4'h5, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        chk("fwd_flush", {fwd_valid, fwd_addr, fwd_data}, {1'b0, 4'h0, 8'h00});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
